// File: rtl/fixed_point_pkg.sv
// Shared constants and helpers for the fixed-point arithmetic pipelines.
// The adder/subtractor and the multiplier both build on these.
package fixed_point_pkg;

    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;
    localparam int SAT_WRAP    = 0;
    localparam int SAT_CLAMP   = 1;

    function automatic int fp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fixed_point_resize.sv
// Combinational requantiser: takes a signed IW.FW value to WIO.WFO.
// Optionally rounds half up, then saturates or wraps.
module fixed_point_resize
    import fixed_point_pkg::*;
#(
    parameter int IW  = 5,
    parameter int FW  = 4,
    parameter int WIO = 5,
    parameter int WFO = 4,
    parameter int SAT = SAT_CLAMP,
    parameter int RND = RND_TRUNC
) (
    input  logic [IW+FW-1:0]   value_in,
    output logic [WIO+WFO-1:0] value_out,
    output logic               overflow
);

    localparam int WIN = IW + FW;
    localparam int WX  = IW + 1 + WFO;
    localparam int WO  = WIO + WFO;

    logic [WX-1:0] aligned;
    logic [WO-1:0] wrapped;
    logic          ovf;

    generate
        if (WFO >= FW) begin : g_pad
            assign aligned = $signed({{(WX-WIN){value_in[WIN-1]}}, value_in}) <<< (WFO - FW);
        end else begin : g_drop
            localparam int D = FW - WFO;
            localparam logic [WIN:0] HALF = (WIN+1)'(1) << (D - 1);
            logic [WIN:0] ext;
            logic [WIN:0] rnd;
            assign ext = {value_in[WIN-1], value_in};
            // One extra integer bit keeps the rounding increment from overflowing.
            if (RND == RND_HALF_UP) begin : g_rnd
                assign rnd = ext + HALF;
            end else begin : g_trunc
                assign rnd = ext;
            end
            assign aligned = rnd[WIN:D];
        end

        if (WX >= WO) begin : g_narrow
            logic [WX-WO:0] top;
            assign top     = aligned[WX-1:WO-1];
            assign wrapped = aligned[WO-1:0];
            assign ovf     = !((&top) || !(|top));
        end else begin : g_wide
            assign wrapped = {{(WO-WX){aligned[WX-1]}}, aligned};
            assign ovf     = 1'b0;
        end
    endgenerate

    always_comb begin
        value_out = wrapped;
        if ((SAT == SAT_CLAMP) && ovf) begin
            value_out = aligned[WX-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
        end
    end

    assign overflow = ovf;

endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// Three-stage valid/ready fixed-point adder/subtractor with mixed Qm.n
// operands, full-precision sum, and round/saturate on the way out.
module fixed_point_addsub_pipe
    import fixed_point_pkg::*;
#(
    parameter int WI1 = 3,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 3,
    parameter int WIO = fp_max(WI1, WI2) + 1,
    parameter int WFO = fp_max(WF1, WF2),
    parameter int SAT = SAT_CLAMP,
    parameter int RND = RND_TRUNC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WI1+WF1-1:0] input1,
    input  logic [WI2+WF2-1:0] input2,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIO+WFO-1:0] FixedPoint_Out,
    output logic               overFlow,
    output logic               ovf_sticky
);

    localparam int IA = fp_max(WI1, WI2);
    localparam int FA = fp_max(WF1, WF2);
    localparam int WA = IA + FA;
    localparam int WR = WA + 1;
    localparam int WO = WIO + WFO;

    logic          en;
    logic [WA-1:0] a_aligned;
    logic [WA-1:0] b_aligned;

    logic          s1_valid_reg;
    logic [WA-1:0] s1_a_reg;
    logic [WA-1:0] s1_b_reg;
    logic          s1_sub_reg;

    logic          s2_valid_reg;
    logic [WR-1:0] s2_sum_reg;
    logic [WR-1:0] a_ext;
    logic [WR-1:0] b_ext;
    logic [WR-1:0] sum_next;

    logic          out_valid_reg;
    logic [WO-1:0] out_data_reg;
    logic          out_ovf_reg;
    logic          ovf_sticky_reg;
    logic [WO-1:0] res_next;
    logic          ovf_next;

    // Every stage moves together; a stalled output freezes the whole pipe.
    assign en       = !out_valid_reg || out_ready;
    assign in_ready = en;

    assign a_aligned = WA'($signed(input1)) <<< (FA - WF1);
    assign b_aligned = WA'($signed(input2)) <<< (FA - WF2);

    // Subtraction as A + ~B + 1 on the already sign-extended operands.
    assign a_ext    = {s1_a_reg[WA-1], s1_a_reg};
    assign b_ext    = {s1_b_reg[WA-1], s1_b_reg} ^ {WR{s1_sub_reg}};
    assign sum_next = a_ext + b_ext + WR'(s1_sub_reg);

    fixed_point_resize #(
        .IW (IA + 1),
        .FW (FA),
        .WIO(WIO),
        .WFO(WFO),
        .SAT(SAT),
        .RND(RND)
    ) u_resize (
        .value_in (s2_sum_reg),
        .value_out(res_next),
        .overflow (ovf_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_sub_reg    <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_sum_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ovf_reg   <= 1'b0;
        end else if (en) begin
            s1_valid_reg  <= in_valid;
            s1_a_reg      <= a_aligned;
            s1_b_reg      <= b_aligned;
            s1_sub_reg    <= sub;
            s2_valid_reg  <= s1_valid_reg;
            s2_sum_reg    <= sum_next;
            out_valid_reg <= s2_valid_reg;
            out_data_reg  <= res_next;
            out_ovf_reg   <= ovf_next && s2_valid_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky_reg <= 1'b0;
        end else if (out_valid_reg && out_ready && out_ovf_reg) begin
            ovf_sticky_reg <= 1'b1;
        end
    end

    assign out_valid      = out_valid_reg;
    assign FixedPoint_Out = out_data_reg;
    assign overFlow       = out_ovf_reg;
    assign ovf_sticky     = ovf_sticky_reg;

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Bench for fixed_point_addsub_pipe: five configurations share one stimulus
// stream; a queue of model results is checked as each result is accepted.
module tb_fixed_point_addsub_pipe;

    localparam int NCFG = 5;

    function automatic int cfg_wio(input int i);
        case (i)
            1, 2:    return 3;
            default: return 5;
        endcase
    endfunction
    function automatic int cfg_wfo(input int i);
        return (i >= 3) ? 2 : 4;
    endfunction
    function automatic int cfg_sat(input int i);
        return (i == 2) ? 0 : 1;
    endfunction
    function automatic int cfg_rnd(input int i);
        return (i == 3) ? 1 : 0;
    endfunction

    typedef struct packed {
        logic [NCFG-1:0][8:0] val;
        logic [NCFG-1:0]      ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [6:0] input1 = '0;
    logic [6:0] input2 = '0;
    logic       sub = 1'b0;

    logic [NCFG-1:0] in_ready_w;
    logic [NCFG-1:0] out_valid_w;
    logic [NCFG-1:0] ovf_w;
    logic [NCFG-1:0] sticky_w;
    logic [8:0]      res_w [NCFG];

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        localparam int P_WIO = cfg_wio(gi);
        localparam int P_WFO = cfg_wfo(gi);
        logic [P_WIO+P_WFO-1:0] res;
        fixed_point_addsub_pipe #(
            .WI1(3), .WF1(4), .WI2(4), .WF2(3),
            .WIO(P_WIO), .WFO(P_WFO), .SAT(cfg_sat(gi)), .RND(cfg_rnd(gi))
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .in_valid      (in_valid),
            .in_ready      (in_ready_w[gi]),
            .input1        (input1),
            .input2        (input2),
            .sub           (sub),
            .out_valid     (out_valid_w[gi]),
            .out_ready     (out_ready),
            .FixedPoint_Out(res),
            .overFlow      (ovf_w[gi]),
            .ovf_sticky    (sticky_w[gi])
        );
        assign res_w[gi] = 9'(res);
    end

    // Reference in units of 1/16: operand B (Q4.3) is doubled to line up.
    function automatic logic [9:0] model(input logic [6:0] a, input logic [6:0] b, input logic s,
                                         input int wio, input int wfo, input int sat, input int rnd);
        int ra, rb, r, q, d, w, hi, lo;
        logic o;
        ra = $signed(a);
        rb = $signed(b);
        rb = rb * 2;
        r  = s ? ra - rb : ra + rb;
        if (wfo >= 4) begin
            q = r <<< (wfo - 4);
        end else begin
            d = 4 - wfo;
            q = (rnd != 0) ? ((r + (1 << (d - 1))) >>> d) : (r >>> d);
        end
        w  = wio + wfo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        o  = (q > hi) || (q < lo);
        if (o && sat != 0) q = (q > hi) ? hi : lo;
        return {o, 9'(q & ((1 << w) - 1))};
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        exp_t e;
        logic [9:0] m;
        if (reset) begin
            sb_q.delete();
        end else begin
            if (out_valid_w[0] && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: out_valid=1 got=%h required=no result pending", res_w[0]);
                end else begin
                    e = sb_q.pop_front();
                    for (int i = 0; i < NCFG; i++) begin
                        n_cmp++;
                        if (res_w[i] !== e.val[i] || ovf_w[i] !== e.ovf[i] || out_valid_w[i] !== 1'b1) begin
                            n_bad++;
                            $display("FAIL sb_result cfg%0d: got val=%h ovf=%b vld=%b required val=%h ovf=%b",
                                     i, res_w[i], ovf_w[i], out_valid_w[i], e.val[i], e.ovf[i]);
                        end else begin
                            $display("cfg%0d result val=%h ovf=%b ok", i, res_w[i], ovf_w[i]);
                        end
                    end
                end
            end
            if (in_valid && in_ready_w[0]) begin
                for (int i = 0; i < NCFG; i++) begin
                    m = model(input1, input2, sub, cfg_wio(i), cfg_wfo(i), cfg_sat(i), cfg_rnd(i));
                    e.val[i] = m[8:0];
                    e.ovf[i] = m[9];
                end
                sb_q.push_back(e);
                $display("accept in1=%h in2=%h sub=%b", input1, input2, sub);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction and counts edges until out_valid rises.
    task automatic send_one(input logic [6:0] a, input logic [6:0] b, input logic s, output int lat);
        in_valid = 1'b1;
        input1   = a;
        input2   = b;
        sub      = s;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_w[0] && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        for (int i = 0; i < NCFG; i++) begin
            n_cmp++;
            if (out_valid_w[i] !== 1'b0 || res_w[i] !== 9'h000 || ovf_w[i] !== 1'b0 ||
                sticky_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_state cfg%0d: got vld=%b val=%h ovf=%b sticky=%b rdy=%b required 0 0 0 0 1",
                         i, out_valid_w[i], res_w[i], ovf_w[i], sticky_w[i], in_ready_w[i]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        int lat;
        send_one(7'h3F, 7'h3F, 1'b0, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL ovf_latency: got %0d required 3", lat);
        end
        n_cmp++;
        if (res_w[1] !== 9'h03F || ovf_w[1] !== 1'b1 || res_w[2] !== 9'h03D || ovf_w[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_values: got sat=%h/%b wrap=%h/%b required 03f/1 03d/1",
                     res_w[1], ovf_w[1], res_w[2], ovf_w[2]);
        end
        n_cmp++;
        if (sticky_w[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL sticky_before_accept: got %b required 0", sticky_w[1]);
        end
        tick();
        n_cmp++;
        if (sticky_w[1] !== 1'b1 || sticky_w[2] !== 1'b1 || sticky_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL sticky_after_accept: got %b%b%b required 110", sticky_w[2], sticky_w[1], sticky_w[0]);
        end
    endtask

    task automatic test_add();
        int lat;
        send_one(7'h18, 7'h12, 1'b0, lat);
        n_cmp++;
        if (lat !== 3 || res_w[0] !== 9'h03C || ovf_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL add_basic: got lat=%0d val=%h ovf=%b required 3 03c 0", lat, res_w[0], ovf_w[0]);
        end
        tick();
    endtask

    task automatic test_sub();
        int lat;
        send_one(7'h40, 7'h3F, 1'b1, lat);
        n_cmp++;
        if (lat !== 3 || res_w[0] !== 9'h142 || ovf_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL sub_basic: got lat=%0d val=%h ovf=%b required 3 142 0", lat, res_w[0], ovf_w[0]);
        end
        tick();
    endtask

    task automatic test_round();
        int lat;
        send_one(7'h02, 7'h00, 1'b0, lat);
        n_cmp++;
        if (res_w[3] !== 9'h001 || res_w[4] !== 9'h000 || ovf_w[3] !== 1'b0 || ovf_w[4] !== 1'b0) begin
            n_bad++;
            $display("FAIL round_lsb: got rnd=%h/%b trunc=%h/%b required 001/0 000/0",
                     res_w[3], ovf_w[3], res_w[4], ovf_w[4]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [6:0] v1 [6];
        logic [6:0] v2 [6];
        logic       vs [6];
        int   sent = 0;
        int   stall_left = 0;
        logic got_first = 1'b0;
        logic acc;
        logic [8:0] held_res = '0;
        logic held_ovf = 1'b0;
        for (int k = 0; k < 6; k++) begin
            v1[k] = 7'($urandom_range(0, 127));
            v2[k] = 7'($urandom_range(0, 127));
            vs[k] = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < 60 && (sent < 6 || sb_q.size() != 0); cyc++) begin
            out_ready = (stall_left == 0);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                input1 = v1[sent];
                input2 = v2[sent];
                sub    = vs[sent];
            end
            #1;
            if (stall_left > 0) begin
                n_cmp++;
                if (in_ready_w[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_in_ready: got %b required 0", in_ready_w[0]);
                end
            end
            acc = in_valid && in_ready_w[0];
            tick();
            if (acc) sent++;
            if (stall_left > 0) begin
                stall_left--;
                n_cmp++;
                if (out_valid_w[0] !== 1'b1 || res_w[0] !== held_res || ovf_w[0] !== held_ovf) begin
                    n_bad++;
                    $display("FAIL stall_hold: got vld=%b val=%h ovf=%b required 1 %h %b",
                             out_valid_w[0], res_w[0], ovf_w[0], held_res, held_ovf);
                end
            end else if (!got_first && out_valid_w[0]) begin
                got_first  = 1'b1;
                stall_left = 4;
                held_res   = res_w[0];
                held_ovf   = ovf_w[0];
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (sent !== 6 || sb_q.size() !== 0 || got_first !== 1'b1) begin
            n_bad++;
            $display("FAIL stream_drain: got sent=%0d pending=%0d required 6 0", sent, sb_q.size());
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        int lat;
        n_cmp++;
        if (sticky_w[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL sticky_pre_reset: got %b required 1", sticky_w[1]);
        end
        in_valid = 1'b1;
        input1 = 7'h3F; input2 = 7'h3F; sub = 1'b0;
        tick();
        input1 = 7'h10; input2 = 7'h08; sub = 1'b1;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        for (int i = 0; i < NCFG; i++) begin
            n_cmp++;
            if (out_valid_w[i] !== 1'b0 || res_w[i] !== 9'h000 || ovf_w[i] !== 1'b0 ||
                sticky_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL midstream_reset cfg%0d: got vld=%b val=%h ovf=%b sticky=%b rdy=%b required 0 0 0 0 1",
                         i, out_valid_w[i], res_w[i], ovf_w[i], sticky_w[i], in_ready_w[i]);
            end
        end
        reset = 1'b0;
        send_one(7'h18, 7'h12, 1'b0, lat);
        n_cmp++;
        if (lat !== 3 || res_w[0] !== 9'h03C) begin
            n_bad++;
            $display("FAIL post_reset_txn: got lat=%0d val=%h required 3 03c", lat, res_w[0]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_add();
        test_sub();
        test_round();
        test_back_to_back();
        test_reset_midstream();
        tick();
        tick();
        n_cmp++;
        if (sb_q.size() !== 0 || out_valid_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL final_idle: got pending=%0d vld=%b required 0 0", sb_q.size(), out_valid_w[0]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
